// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: operation codes,
// FSM state encodings and small helpers decoding an operation into its carry setup.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Subtraction is A + ~B + c0; bit 0 of the encoding marks the subtracting ops.
  function automatic logic op_is_sub(input op_e op);
    return op[0];
  endfunction

  function automatic logic op_carry0(input op_e op, input logic cin);
    logic c0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/addsub_seq_add_chunk.sv
// Combinational carry-lookahead adder for one chunk; also exposes the carry
// into the MSB so the caller can form signed overflow.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  // Each carry is the OR of every generate term propagated up to it, plus cin
  // propagated through all lower bits, so no carry depends on another carry.
  function automatic logic [W:0] cla_carries(input logic [W-1:0] g,
                                             input logic [W-1:0] p,
                                             input logic         cin);
    logic [W:0] c;
    logic       term;
    c = '0;
    c[0] = cin;
    for (int i = 1; i <= W; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  assign gen    = a_i & b_i;
  assign prop   = a_i ^ b_i;
  assign carry  = cla_carries(gen, prop, cin_i);
  assign sum_o  = prop ^ carry[W-1:0];
  assign cout_o = carry[W];
  assign cmsb_o = carry[W-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: operands are latched on start and summed one
// CHUNK-bit slice per cycle, LSB slice first, with the slice carry registered.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               v_q, v_d;
  logic               z_q, z_d;
  logic               n_q, n_d;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;
  logic               chunk_cmsb;
  logic               last_chunk;
  op_e                op_in;

  assign op_in      = op_e'(op);
  assign chunk_a    = a_q[cnt_q*CHUNK +: CHUNK];
  assign chunk_b    = b_q[cnt_q*CHUNK +: CHUNK];
  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  add_chunk #(.W(CHUNK)) u_add_chunk (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout),
    .cmsb_o (chunk_cmsb)
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    v_d      = v_q;
    z_d      = z_q;
    n_d      = n_q;

    case (state_q)
      ST_RUN: begin
        result_d[cnt_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          state_d = ST_DONE;
          cout_d  = chunk_cout;
          v_d     = chunk_cmsb ^ chunk_cout;
          z_d     = (result_d == '0);
          n_d     = result_d[WIDTH-1];
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; B is stored pre-inverted
        // for subtraction so the RUN datapath is a plain adder.
        if (start) begin
          state_d = ST_RUN;
          a_d     = A;
          b_d     = op_is_sub(op_in) ? ~B : B;
          carry_d = op_carry0(op_in, Cin);
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign Result = result_q;
  assign Cout   = cout_q;
  assign V      = v_q;
  assign Z      = z_q;
  assign N      = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: a 32/8 instance for the main scenarios and a
// 16/4 instance for the alternate geometry.
module tb_addsub_seq;
  import addsub_seq_pkg::*;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        Cin;
  logic        busy, done, Cout, V, Z, N;
  logic [31:0] Result;

  logic        start16;
  logic [1:0]  op16;
  logic [15:0] A16, B16;
  logic        Cin16;
  logic        busy16, done16, Cout16, V16, Z16, N16;
  logic [15:0] Result16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clk), .clear(clear), .start(start), .op(op), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Result(Result), .Cout(Cout), .V(V), .Z(Z), .N(N)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clock(clk), .clear(clear), .start(start16), .op(op16), .A(A16), .B(B16), .Cin(Cin16),
    .busy(busy16), .done(done16), .Result(Result16), .Cout(Cout16), .V(V16), .Z(Z16), .N(N16)
  );

  // Issues one request and scrambles the inputs right after acceptance;
  // edges = number of edges from the accepting edge (1) to done, -1 on timeout.
  task automatic run32(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic cin_v, output int edges);
    op = op_v; A = a_v; B = b_v; Cin = cin_v; start = 1'b1;
    edges = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0; A = $urandom; B = $urandom; Cin = ~cin_v; op = ~op_v;
      end
      if (done) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0; Cin = 1'b0;
    start16 = 1'b0; op16 = 2'b00; A16 = '0; B16 = '0; Cin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++;
    if ({busy, done, Cout, V, Z, N} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {busy, done, Cout, V, Z, N});
    end
    n_cmp++;
    if (Result !== 32'h0) begin
      n_bad++; $display("FAIL reset_result: got %h want 00000000", Result);
    end
  endtask

  task automatic test_add_wrap;
    int edges;
    run32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, edges);
    n_cmp++;
    if (edges !== 5) begin
      n_bad++; $display("FAIL add_latency: got %0d want 5", edges);
    end
    n_cmp++;
    if (Result !== 32'h0) begin
      n_bad++; $display("FAIL add_result: got %h want 00000000", Result);
    end
    n_cmp++;
    if ({Cout, V, Z, N} !== 4'b1010) begin
      n_bad++; $display("FAIL add_flags CVZN: got %b want 1010", {Cout, V, Z, N});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL done_one_cycle busy/done: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_sub;
    int edges;
    run32(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, edges);
    n_cmp++;
    if (Result !== 32'h7FFF_FFFF) begin
      n_bad++; $display("FAIL sub_ovf_result: got %h want 7fffffff", Result);
    end
    n_cmp++;
    if ({Cout, V, Z, N} !== 4'b1100) begin
      n_bad++; $display("FAIL sub_ovf_flags CVZN: got %b want 1100", {Cout, V, Z, N});
    end
    run32(OP_SUB, 32'd5, 32'd7, 1'b1, edges);
    n_cmp++;
    if (Result !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL sub_neg_result: got %h want fffffffe", Result);
    end
    n_cmp++;
    if ({Cout, V, Z, N} !== 4'b0001) begin
      n_bad++; $display("FAIL sub_neg_flags CVZN: got %b want 0001", {Cout, V, Z, N});
    end
  endtask

  task automatic test_ignore_start;
    int n_done = 0;
    op = OP_ADD; A = 32'd1; B = 32'd2; Cin = 1'b0; start = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL ignore_busy: got %b want 1", busy);
        end
      end
      if (e == 2) begin
        start = 1'b1; A = 32'd9;
      end
      if (e == 3) start = 1'b0;
      if (done) n_done++;
      if (e == 5) begin
        n_cmp++;
        if (Result !== 32'h3) begin
          n_bad++; $display("FAIL ignore_result: got %h want 00000003", Result);
        end
      end
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL ignore_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_clear_abort;
    int  edges;
    logic seen_done = 1'b0;
    op = OP_SUB; A = 32'd10; B = 32'd3; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_cmp++;
    if ({busy, done, Cout, V, Z, N} !== 6'b0 || Result !== 32'h0) begin
      n_bad++;
      $display("FAIL clear_outputs: got flags %b result %h want 000000 00000000",
               {busy, done, Cout, V, Z, N}, Result);
    end
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL clear_no_done: got %b want 0", seen_done);
    end
    // clear must win over a simultaneous start
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL clear_priority_busy: got %b want 0", busy);
    end
    run32(OP_ADD, 32'd4, 32'd4, 1'b0, edges);
    n_cmp++;
    if (edges !== 5 || Result !== 32'h8) begin
      n_bad++; $display("FAIL post_clear_add: got edges %0d result %h want 5 00000008", edges, Result);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    run32(OP_ADC, 32'h7FFF_FFFF, 32'h0, 1'b1, edges);
    n_cmp++;
    if (Result !== 32'h8000_0000 || {Cout, V, Z, N} !== 4'b0101) begin
      n_bad++; $display("FAIL b2b_adc: got %h CVZN %b want 80000000 0101", Result, {Cout, V, Z, N});
    end
    run32(OP_SBB, 32'h0, 32'h0, 1'b0, edges);
    n_cmp++;
    if (edges !== 5) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d want 5", edges);
    end
    n_cmp++;
    if (Result !== 32'hFFFF_FFFF || {Cout, V, Z, N} !== 4'b0001) begin
      n_bad++; $display("FAIL b2b_sbb: got %h CVZN %b want ffffffff 0001", Result, {Cout, V, Z, N});
    end
  endtask

  task automatic test_w16;
    int edges = -1;
    op16 = OP_SUB; A16 = 16'h0000; B16 = 16'h0001; Cin16 = 1'b0; start16 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start16 = 1'b0; A16 = 16'h1234; B16 = 16'h4321;
      end
      if (done16) begin
        edges = e;
        break;
      end
    end
    n_cmp++;
    if (edges !== 5) begin
      n_bad++; $display("FAIL w16_latency: got %0d want 5", edges);
    end
    n_cmp++;
    if (Result16 !== 16'hFFFF || {Cout16, V16, Z16, N16} !== 4'b0001) begin
      n_bad++; $display("FAIL w16_sub: got %h CVZN %b want ffff 0001", Result16, {Cout16, V16, Z16, N16});
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_ignore_start();
    test_clear_abort();
    test_back_to_back();
    test_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clock  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port clear  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: request; accepted only in IDLE or DONE.
REQ-006 SHALL have port op  input  2: 00 ADD (A+B), 01 SUB (A-B), 10 ADC (A+B+Cin), 11 SBB (A-B-!Cin).
REQ-007 SHALL have ports A, B  input  WIDTH: operands; Cin  input  1: carry-in for ADC/SBB.
REQ-008 SHALL have port busy  output  1: high in RUN.
REQ-009 SHALL have port done  output  1: one-cycle pulse, result valid.
REQ-010 SHALL have port Result  output  WIDTH: sum/difference.
REQ-011 SHALL have ports Cout, V, Z, N  output  1 each: carry-out (1 = no borrow for SUB/SBB), signed overflow, zero, negative.

Function
REQ-012 SHALL implement FSM IDLE -> RUN on accepted start; RUN -> DONE after NCHUNK RUN cycles; DONE -> RUN if start, else IDLE.
REQ-013 SHALL latch op, A, B, Cin on the accepting edge; input changes afterwards SHALL NOT affect the operation.
REQ-014 SHALL subtract as A + ~B + c0, c0 = 1 for SUB, Cin for SBB; c0 = 0 for ADD, Cin for ADC.
REQ-015 SHALL process chunk i (bits i*CHUNK..i*CHUNK+CHUNK-1, LSB chunk first) in RUN cycle i, carrying the chunk carry-out in a register into chunk i+1.
REQ-016 SHALL assert done in the cycle after the NCHUNK-th RUN edge: start accepted at edge k -> done high between edges k+NCHUNK and k+NCHUNK+1 (latency NCHUNK+1 edges).
REQ-017 SHALL hold Result and flags stable from done until the edge after the next accepted start; intermediate chunks MAY update Result during RUN.
REQ-018 SHALL compute V = carry into MSB XOR Cout; Z = (Result == 0); N = Result[WIDTH-1]; all valid when done high.
REQ-019 SHALL ignore start while busy (no restart, no queueing).
REQ-020 SHALL accept start during DONE (back-to-back), giving done pulses NCHUNK+1 cycles apart.
REQ-021 SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-022 SHALL, when clear high at an edge, force state IDLE, busy=0, done=0, Result=0, Cout=V=Z=N=0, internal carry=0.
REQ-023 SHALL abort an in-flight operation on clear without producing done; clear SHALL take priority over simultaneous start.

Structure
REQ-024 SHALL place op encodings (ADD/SUB/ADC/SBB) and FSM state encodings in a shared package/include used by the ALU and bench.
REQ-025 SHALL instantiate one sub-module add_chunk (CHUNK-bit combinational carry-lookahead adder: A, B, Cin -> Sum, Cout, carry into MSB).

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-026 ADD A=0xFFFFFFFF, B=0x00000001 -> Result 0x00000000, Cout 1, Z 1, V 0, N 0; done 5 edges after start.
REQ-027 SUB A=0x80000000, B=0x00000001 -> Result 0x7FFFFFFF, Cout 1, V 1, N 0; SUB A=5, B=7 -> 0xFFFFFFFE, Cout 0, N 1, V 0.
REQ-028 Start ADD 1+2, re-pulse start with A=9 during RUN -> ignored, Result 0x00000003, exactly one done.
REQ-029 Start SUB, assert clear 2 cycles later -> no done, all outputs 0, next ADD 4+4 -> 0x00000008 normally.
REQ-030 Back-to-back: ADC 0x7FFFFFFF+0+Cin=1 then start in DONE with SBB 0-0 Cin=0 -> 0x80000000 V 1, then 0xFFFFFFFF Cout 0; done pulses 5 cycles apart.
REQ-031 WIDTH=16, CHUNK=4: SUB 0x0000-0x0001 -> 0xFFFF, Cout 0, N 1; done 5 edges after start.
